// File: rtl/handshake_const_to_ctrl.sv
// Sink for a constant-producing data channel: compares each accepted token against
// CONST_VALUE, forwards a control-only token with an error bit through a 2-entry buffer.
module handshake_const_to_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CONST_VALUE = 15,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  ctrl_valid,
    input  logic                  ctrl_ready,
    output logic                  ctrl_err,
    input  logic                  clear,
    output logic [CNT_WIDTH-1:0]  token_count,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic                  err_sticky
);

    localparam logic [DATA_WIDTH-1:0] CONST_VEC = DATA_WIDTH'(CONST_VALUE);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic   head_err_reg, head_err_next;
    logic   tail_err_reg, tail_err_next;

    logic [CNT_WIDTH-1:0] token_count_reg;
    logic [CNT_WIDTH-1:0] mismatch_count_reg;
    logic                 err_sticky_reg;

    logic accept;
    logic transfer;
    logic in_err;

    // Handshake outputs depend only on state, so ins_ready never follows ctrl_ready.
    assign ins_ready  = (state_reg != TWO);
    assign ctrl_valid = (state_reg != EMPTY);
    assign ctrl_err   = (state_reg != EMPTY) & head_err_reg;

    assign accept   = ins_valid & ins_ready;
    assign transfer = ctrl_valid & ctrl_ready;
    assign in_err   = (ins != CONST_VEC);

    always_comb begin
        state_next    = state_reg;
        head_err_next = head_err_reg;
        tail_err_next = tail_err_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next    = ONE;
                    head_err_next = in_err;
                end
            end
            ONE: begin
                if (accept && transfer) begin
                    head_err_next = in_err;
                end else if (accept) begin
                    state_next    = TWO;
                    tail_err_next = in_err;
                end else if (transfer) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (transfer) begin
                    state_next    = ONE;
                    head_err_next = tail_err_reg;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= EMPTY;
            head_err_reg <= 1'b0;
            tail_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            head_err_reg <= head_err_next;
            tail_err_reg <= tail_err_next;
        end
    end

    // Statistics: clear wins over any same-cycle event; counters saturate at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            token_count_reg    <= '0;
            mismatch_count_reg <= '0;
            err_sticky_reg     <= 1'b0;
        end else if (clear) begin
            token_count_reg    <= '0;
            mismatch_count_reg <= '0;
            err_sticky_reg     <= 1'b0;
        end else begin
            if (transfer && !(&token_count_reg)) begin
                token_count_reg <= token_count_reg + 1'b1;
            end
            if (accept && in_err) begin
                err_sticky_reg <= 1'b1;
                if (!(&mismatch_count_reg)) begin
                    mismatch_count_reg <= mismatch_count_reg + 1'b1;
                end
            end
        end
    end

    assign token_count    = token_count_reg;
    assign mismatch_count = mismatch_count_reg;
    assign err_sticky     = err_sticky_reg;

endmodule

// File: tb/tb_handshake_const_to_ctrl.sv
// Directed bench for handshake_const_to_ctrl; a second instance with 4-bit
// counters shares the stimulus to exercise saturation.
module tb_handshake_const_to_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic        ctrl_err;
    logic        clear;
    logic [15:0] token_count;
    logic [15:0] mismatch_count;
    logic        err_sticky;

    logic        ins_ready4;
    logic        ctrl_valid4;
    logic        ctrl_err4;
    logic [3:0]  token_count4;
    logic [3:0]  mismatch_count4;
    logic        err_sticky4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    handshake_const_to_ctrl dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_err(ctrl_err),
        .clear(clear), .token_count(token_count), .mismatch_count(mismatch_count),
        .err_sticky(err_sticky)
    );

    handshake_const_to_ctrl #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready4),
        .ctrl_valid(ctrl_valid4), .ctrl_ready(ctrl_ready), .ctrl_err(ctrl_err4),
        .clear(clear), .token_count(token_count4), .mismatch_count(mismatch_count4),
        .err_sticky(err_sticky4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] alt [5];
        alt[0] = 32'd0; alt[1] = 32'd15; alt[2] = 32'd0; alt[3] = 32'd15; alt[4] = 32'd0;

        rst = 1'b0; ins = 32'd0; ins_valid = 1'b0; ctrl_ready = 1'b0; clear = 1'b0;
        #12;
        check("rst_ins_ready",  32'(ins_ready), 32'd1);
        check("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
        check("rst_ctrl_err",   32'(ctrl_err), 32'd0);
        check("rst_tokens",     32'(token_count), 32'd0);
        check("rst_mismatch",   32'(mismatch_count), 32'd0);
        check("rst_sticky",     32'(err_sticky), 32'd0);
        rst = 1'b1;
        tick();

        // Stream of matching tokens at full rate
        ins = 32'd15; ins_valid = 1'b1; ctrl_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("stream%0d_valid", i), 32'(ctrl_valid), 32'd1);
            check($sformatf("stream%0d_err", i),   32'(ctrl_err), 32'd0);
            check($sformatf("stream%0d_ready", i), 32'(ins_ready), 32'd1);
        end
        ins_valid = 1'b0;
        tick();
        check("stream_tokens",   32'(token_count), 32'd8);
        check("stream_mismatch", 32'(mismatch_count), 32'd0);
        check("stream_sticky",   32'(err_sticky), 32'd0);
        check("stream_drained",  32'(ctrl_valid), 32'd0);

        // Backpressure: fill both entries, third token held
        ctrl_ready = 1'b0; ins_valid = 1'b1; ins = 32'd15;
        tick();
        check("bp_one_ready", 32'(ins_ready), 32'd1);
        ins = 32'd7;
        tick();
        check("bp_two_ready", 32'(ins_ready), 32'd0);
        ins = 32'd15;
        tick();
        check("bp_held_ready",  32'(ins_ready), 32'd0);
        check("bp_head_err0",   32'(ctrl_err), 32'd0);
        check("bp_mismatch",    32'(mismatch_count), 32'd1);
        check("bp_sticky",      32'(err_sticky), 32'd1);
        ctrl_ready = 1'b1;
        tick();
        check("bp_head_err1",   32'(ctrl_err), 32'd1);
        check("bp_ready_again", 32'(ins_ready), 32'd1);
        tick();
        check("bp_head_err2",   32'(ctrl_err), 32'd0);
        ins_valid = 1'b0;
        tick();
        check("bp_empty",       32'(ctrl_valid), 32'd0);
        check("bp_tokens",      32'(token_count), 32'd11);

        // Clear alone, then simultaneous accept/transfer in ONE
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_tokens", 32'(token_count), 32'd0);
        check("clr_sticky", 32'(err_sticky), 32'd0);
        ins_valid = 1'b1; ins = 32'd15;
        tick();
        for (int i = 0; i < 5; i++) begin
            ins = alt[i];
            tick();
            check($sformatf("alt%0d_err", i),    32'(ctrl_err), (alt[i] != 32'd15) ? 32'd1 : 32'd0);
            check($sformatf("alt%0d_valid", i),  32'(ctrl_valid), 32'd1);
            check($sformatf("alt%0d_tokens", i), 32'(token_count), 32'(i + 1));
        end
        check("alt_mismatch", 32'(mismatch_count), 32'd3);

        // Clear coinciding with transfer and a mismatching accept
        clear = 1'b1; ins = 32'd0;
        tick();
        clear = 1'b0;
        check("clrx_tokens",   32'(token_count), 32'd0);
        check("clrx_mismatch", 32'(mismatch_count), 32'd0);
        check("clrx_sticky",   32'(err_sticky), 32'd0);
        check("clrx_head_err", 32'(ctrl_err), 32'd1);
        ins_valid = 1'b0;
        tick();
        check("clrx_drain_tokens", 32'(token_count), 32'd1);

        // Saturation: 20 mismatching tokens
        ins = 32'hFFFF_FFFF; ins_valid = 1'b1;
        repeat (20) tick();
        ins_valid = 1'b0;
        tick();
        check("sat4_mismatch", 32'(mismatch_count4), 32'd15);
        check("sat4_tokens",   32'(token_count4), 32'd15);
        check("sat16_mismatch", 32'(mismatch_count), 32'd20);
        check("sat16_tokens",   32'(token_count), 32'd21);

        // Asynchronous reset while full
        ctrl_ready = 1'b0; ins_valid = 1'b1; ins = 32'd15;
        tick();
        tick();
        check("ar_full_ready", 32'(ins_ready), 32'd0);
        #3 rst = 1'b0;
        #1;
        check("ar_valid",  32'(ctrl_valid), 32'd0);
        check("ar_ready",  32'(ins_ready), 32'd1);
        check("ar_tokens", 32'(token_count), 32'd0);
        check("ar_sticky", 32'(err_sticky), 32'd0);
        ins_valid = 1'b0; ctrl_ready = 1'b1;
        #1 rst = 1'b1;
        tick();
        check("ar_post_valid0", 32'(ctrl_valid), 32'd0);
        tick();
        check("ar_post_valid1", 32'(ctrl_valid), 32'd0);
        check("ar_post_tokens", 32'(token_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/handshake_const_to_ctrl.md
Name: handshake_const_to_ctrl

Overview:
- Receiving end of a constant-producing data channel.
- Accepts data tokens, checks each against the expected constant, and strips the data, emitting a control-only token downstream with a per-token error bit.
- Contains a 2-entry elastic buffer, so `ins_ready` is registered: it never depends combinationally on `ctrl_ready`.
- Keeps saturating token/mismatch counters and a sticky error flag, used as a protocol monitor/sink at constant-fed dataflow boundaries.

Parameters:
- DATA_WIDTH, 32, width of the incoming data channel.
- CONST_VALUE, 15, expected token value; zero-extended or truncated to DATA_WIDTH.
- CNT_WIDTH, 16, width of both statistics counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- ins  input  DATA_WIDTH  incoming data token.
- ins_valid  input  1  incoming token valid.
- ins_ready  output  1  block can accept a token.
- ctrl_valid  output  1  outgoing control token valid.
- ctrl_ready  input  1  downstream accepts control token.
- ctrl_err  output  1  head token mismatched CONST_VALUE; valid only while ctrl_valid=1.
- clear  input  1  synchronous clear of counters and sticky flag.
- token_count  output  CNT_WIDTH  control tokens delivered (ctrl handshakes), saturating.
- mismatch_count  output  CNT_WIDTH  accepted input tokens that mismatched, saturating.
- err_sticky  output  1  set on any accepted mismatch; held until clear or reset.

Behaviour:
- Reset (rst=0, async):
  - Buffer EMPTY; ins_ready=1, ctrl_valid=0, ctrl_err=0.
  - token_count=0, mismatch_count=0, err_sticky=0.
  - Reset mid-operation discards buffered tokens immediately.
- Handshakes:
  - Input accept: ins_valid & ins_ready. Output transfer: ctrl_valid & ctrl_ready.
  - ctrl_valid never drops without a transfer; ctrl_err is stable while ctrl_valid=1 and ctrl_ready=0.
- Match rule: at input accept, err = (ins != CONST_VALUE[DATA_WIDTH-1:0]). Only the err bit is stored per entry; data is discarded.
- Buffer FSM, states EMPTY, ONE, TWO:
  - ins_ready = (state != TWO); ctrl_valid = (state != EMPTY); both driven from registers/state only.
  - EMPTY: accept -> ONE.
  - ONE: accept only -> TWO. Transfer only -> EMPTY. Accept and transfer together -> ONE (new token becomes head next cycle).
  - TWO: transfer -> ONE (second entry becomes head). No accept is possible.
- Order: strict FIFO; ctrl_err always reflects the oldest buffered token.
- Latency and throughput:
  - A token accepted in cycle N is visible as ctrl_valid at N+1 at the earliest.
  - Sustained throughput is 1 token/cycle when ctrl_ready=1.
- Counters:
  - token_count += 1 on each output transfer. mismatch_count += 1 on each accepted mismatching token.
  - Both hold at 2^CNT_WIDTH-1 (no wrap).
  - err_sticky is set on an accepted mismatch.
- clear=1: token_count, mismatch_count and err_sticky go to 0 next cycle.
  - Clear has priority: a transfer or mismatch in the same cycle is not counted.
  - The buffer and handshakes are unaffected by clear.
- ins is don't-care when ins_valid=0. The block has no input-side protocol checks beyond the value compare.

Test Plan:
- Reset then stream ins=15 for 8 cycles with ctrl_ready=1 -> ctrl_valid from cycle 1 onward, ctrl_err=0 throughout, ins_ready stays 1, token_count=8, mismatch_count=0, err_sticky=0.
- Hold ctrl_ready=0 and offer 3 tokens (15, 7, 15) -> first two accepted, ins_ready=0 after the second, third held. Raise ctrl_ready -> ctrl_err sequence 0,1,0, mismatch_count=1, err_sticky=1.
- Simultaneous accept and transfer in state ONE for 5 cycles with ins alternating 15/0 -> state stays ONE, ctrl_err alternates one cycle behind input, token_count increments every cycle.
- Assert clear in a cycle containing both a transfer and a mismatching accept -> counters 0 and err_sticky=0 next cycle; the mismatching token still shows ctrl_err=1 at the head.
- CNT_WIDTH=4: deliver 20 mismatching tokens -> both counters saturate at 15.
- Assert rst=0 asynchronously while in TWO with ctrl_ready=0 -> ctrl_valid=0 and ins_ready=1 immediately without a clock edge. After release, an empty buffer with no stale tokens emitted.
